// File: rtl/lieat_ifu_ibuf.sv
`default_nettype none
// ============================================================================
// Module      : lieat_ifu_ibuf
// Description : Instruction buffer between the fetch response port and the
//               decode stage. A small circular FIFO lets fetch keep returning
//               instructions while decode is stalled. Everything buffered is
//               dropped on an execute-stage flush.
//
//               Outputs come only from stored state, so there is no
//               combinational path from if_i_* to id_o_*. There is also none
//               from id_o_ready to if_i_ready: a full buffer refuses a write
//               even when decode is reading in the same cycle.
//
// Ports       : clock            - rising-edge clock
//               reset            - asynchronous, active-high reset
//               if_i_valid       - fetch response valid
//               if_i_ready       - buffer can accept an entry
//               if_i_pc          - pc of fetched instruction
//               if_i_inst        - fetched instruction
//               if_i_prdt_taken  - branch predictor taken flag
//               flush_req        - execute-stage flush, drops all contents
//               id_o_valid       - head entry valid toward decode
//               id_o_ready       - decode accepts head entry
//               id_o_pc          - head pc
//               id_o_inst        - head instruction
//               id_o_prdt_taken  - head prediction flag
//               ibuf_count       - number of occupied entries
//               ibuf_empty       - buffer holds no entries
//
// Revision    : 1.0 - initial release
// ============================================================================
module lieat_ifu_ibuf #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     if_i_valid,
    output logic                     if_i_ready,
    input  logic [XLEN-1:0]          if_i_pc,
    input  logic [XLEN-1:0]          if_i_inst,
    input  logic                     if_i_prdt_taken,

    input  logic                     flush_req,

    output logic                     id_o_valid,
    input  logic                     id_o_ready,
    output logic [XLEN-1:0]          id_o_pc,
    output logic [XLEN-1:0]          id_o_inst,
    output logic                     id_o_prdt_taken,

    output logic [$clog2(DEPTH):0]   ibuf_count,
    output logic                     ibuf_empty
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_aw = $clog2(DEPTH);   // pointer width
    localparam int c_cw = c_aw + 1;        // count width, can hold DEPTH

    localparam logic [c_cw-1:0] c_count_full = c_cw'(DEPTH);
    localparam logic [c_cw-1:0] c_count_zero = '0;
    localparam logic [c_cw-1:0] c_count_one  = c_cw'(1);
    localparam logic [c_aw-1:0] c_ptr_one    = c_aw'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // Payload storage is deliberately not reset: id_o_valid masks stale data.
    logic [XLEN-1:0]  r_pc_mem    [DEPTH];
    logic [XLEN-1:0]  r_inst_mem  [DEPTH];
    logic             r_taken_mem [DEPTH];

    // Pointers are exactly c_aw bits, so they wrap from DEPTH-1 to 0 on their
    // own. The occupancy lives in its own register rather than being derived
    // from the pointers, which would need an extra wrap bit.
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_cw-1:0]  r_count;

    // ------------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------------
    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_rd;

    assign w_full  = (r_count == c_count_full);
    assign w_empty = (r_count == c_count_zero);

    // Flush masks both sides, so nothing presented in the flush cycle is
    // either stored or reported as consumed.
    assign if_i_ready = ~w_full  & ~flush_req;
    assign id_o_valid = ~w_empty & ~flush_req;

    assign w_wr = if_i_valid & if_i_ready;
    assign w_rd = id_o_valid & id_o_ready;

    // ------------------------------------------------------------------------
    // Output view of the head entry
    // ------------------------------------------------------------------------
    assign id_o_pc         = r_pc_mem[r_rptr];
    assign id_o_inst       = r_inst_mem[r_rptr];
    assign id_o_prdt_taken = r_taken_mem[r_rptr];

    assign ibuf_count = r_count;
    assign ibuf_empty = w_empty;

    // ------------------------------------------------------------------------
    // Pointer and occupancy control
    // ------------------------------------------------------------------------
    // Because the count is reset asynchronously, id_o_valid falls as soon as
    // reset rises, with no clock edge needed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_req) begin
            // Returning both pointers to zero puts the first instruction
            // after the redirect into entry 0.
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            // A write and a read in the same cycle leave the count unchanged.
            if (w_wr && !w_rd) begin
                r_count <= r_count + c_count_one;
            end else if (w_rd && !w_wr) begin
                r_count <= r_count - c_count_one;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------------
    // w_wr is already low during a flush, so no flush check is needed here.
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_pc_mem[r_wptr]    <= if_i_pc;
            r_inst_mem[r_wptr]  <= if_i_inst;
            r_taken_mem[r_wptr] <= if_i_prdt_taken;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lieat_ifu_ibuf.sv
`default_nettype none
// ============================================================================
// Module      : tb_lieat_ifu_ibuf
// Description : Self-checking bench for lieat_ifu_ibuf. Table of directed
//               vectors followed by hand-written streaming, flush and
//               asynchronous-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lieat_ifu_ibuf;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic             clk;
    logic             rst;
    logic             if_i_valid;
    logic             if_i_ready;
    logic [XLEN-1:0]  if_i_pc;
    logic [XLEN-1:0]  if_i_inst;
    logic             if_i_prdt_taken;
    logic             flush_req;
    logic             id_o_valid;
    logic             id_o_ready;
    logic [XLEN-1:0]  id_o_pc;
    logic [XLEN-1:0]  id_o_inst;
    logic             id_o_prdt_taken;
    logic [2:0]       ibuf_count;
    logic             ibuf_empty;

    int total = 0;
    int bad   = 0;

    lieat_ifu_ibuf #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock           (clk),
        .reset           (rst),
        .if_i_valid      (if_i_valid),
        .if_i_ready      (if_i_ready),
        .if_i_pc         (if_i_pc),
        .if_i_inst       (if_i_inst),
        .if_i_prdt_taken (if_i_prdt_taken),
        .flush_req       (flush_req),
        .id_o_valid      (id_o_valid),
        .id_o_ready      (id_o_ready),
        .id_o_pc         (id_o_pc),
        .id_o_inst       (id_o_inst),
        .id_o_prdt_taken (id_o_prdt_taken),
        .ibuf_count      (ibuf_count),
        .ibuf_empty      (ibuf_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector: inputs held for one cycle; expected outputs are sampled
    // before the rising edge, so they reflect the state left by the previous
    // vector plus this vector's flush_req.
    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        tk;
        logic        rdy;
        logic        fl;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_tk;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic tk, input logic rdy, input logic fl);
        if_i_valid      = v;
        if_i_pc         = pc;
        if_i_inst       = inst;
        if_i_prdt_taken = tk;
        id_o_ready      = rdy;
        flush_req       = fl;
    endtask

    task automatic check_outs(input string tag, input logic e_ir, input logic e_ov,
                              input logic [31:0] e_pc, input logic [31:0] e_inst,
                              input logic e_tk, input logic [2:0] e_cnt);
        chk({tag, ".if_i_ready"}, {31'd0, if_i_ready}, {31'd0, e_ir});
        chk({tag, ".id_o_valid"}, {31'd0, id_o_valid}, {31'd0, e_ov});
        chk({tag, ".count"},      {29'd0, ibuf_count}, {29'd0, e_cnt});
        chk({tag, ".empty"},      {31'd0, ibuf_empty}, {31'd0, (e_cnt == 3'd0)});
        if (e_ov) begin
            chk({tag, ".pc"},   id_o_pc,   e_pc);
            chk({tag, ".inst"}, id_o_inst, e_inst);
            chk({tag, ".tk"},   {31'd0, id_o_prdt_taken}, {31'd0, e_tk});
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //         v   pc            inst          tk    rdy   fl    ir    ov    e_pc          e_inst        e_tk  cnt
        vecs[0]  = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 3'd0};
        // empty: no bypass even though a write is presented
        vecs[1]  = '{1'b1, 32'h80000000, 32'h00000013, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 3'd0};
        vecs[2]  = '{1'b1, 32'h80000004, 32'h000000a4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80000000, 32'h00000013, 1'b0, 3'd1};
        vecs[3]  = '{1'b1, 32'h80000008, 32'h000000a8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80000000, 32'h00000013, 1'b0, 3'd2};
        vecs[4]  = '{1'b1, 32'h8000000c, 32'h000000ac, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80000000, 32'h00000013, 1'b0, 3'd3};
        // full: fifth write refused
        vecs[5]  = '{1'b1, 32'h80000010, 32'h000000b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'h00000013, 1'b0, 3'd4};
        // full with a read: still refused in the same cycle
        vecs[6]  = '{1'b1, 32'h80000010, 32'h000000b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'h00000013, 1'b0, 3'd4};
        vecs[7]  = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80000004, 32'h000000a4, 1'b1, 3'd3};
        vecs[8]  = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80000008, 32'h000000a8, 1'b0, 3'd2};
        vecs[9]  = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8000000c, 32'h000000ac, 1'b1, 3'd1};
        vecs[10] = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 3'd0};
        vecs[11] = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 3'd0};

        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v, vecs[i].pc, vecs[i].inst, vecs[i].tk, vecs[i].rdy, vecs[i].fl);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_pc,
                       vecs[i].e_inst, vecs[i].e_tk, vecs[i].e_cnt);
            step();
        end

        // ---------------- streaming with pointer wrap ----------------
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h100 + 32'(4 * k), 32'h1000 + 32'(k), k[0], 1'b1, 1'b0);
            #1;
            if (k == 0)
                check_outs("stream0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 3'd0);
            else
                check_outs($sformatf("stream%0d", k), 1'b1, 1'b1, 32'h100 + 32'(4 * (k - 1)),
                           32'h1000 + 32'(k - 1), ~k[0], 3'd1);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        #1;
        check_outs("stream_tail", 1'b1, 1'b1, 32'h124, 32'h1009, 1'b1, 3'd1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check_outs("stream_done", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 3'd0);
        step();

        // ---------------- flush with three entries held ----------------
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h400 + 32'(4 * k), 32'h4000 + 32'(k), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 32'h200, 32'h2000, 1'b0, 1'b1, 1'b1);
        #1;
        check_outs("flush_cyc", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 3'd3);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check_outs("flush_after", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 3'd0);
        drive(1'b1, 32'h300, 32'h00000033, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check_outs("flush_redirect", 1'b1, 1'b1, 32'h300, 32'h00000033, 1'b1, 3'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // ---------------- asynchronous reset mid-stream ----------------
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h500 + 32'(4 * k), 32'h5000 + 32'(k), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check_outs("pre_reset", 1'b1, 1'b1, 32'h500, 32'h5000, 1'b0, 3'd2);
        #1;                     // well away from any clock edge
        rst = 1'b1;
        #1;
        chk("async_rst.id_o_valid", {31'd0, id_o_valid}, 32'd0);
        chk("async_rst.count",      {29'd0, ibuf_count}, 32'd0);
        step();
        rst = 1'b0;
        step();
        check_outs("post_reset", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
